pc_branch_ctrl: RTL and testbench

- Program-counter and conditional-branch controller. Sits directly downstream of the accumulator/bus equality comparator and consumes its zero flag z.
- Advances the PC on instruction-fetch handshakes.
- Evaluates JMP/JZ/JNZ requests from the decoder one cycle after request, so comparator operands have settled.
- Redirects the PC and issues a one-cycle fetch bubble on a taken branch.

---
 rtl/pc_pkg.sv | 18 +
 rtl/br_cond_eval.sv | 30 +++
 rtl/pc_branch_ctrl.sv | 151 +++++++++++++++
 tb/tb_pc_branch_ctrl.sv | 251 +++++++++++++++++++++++++
 4 files changed

// File: rtl/pc_pkg.sv
// rtl/pc_pkg.sv - shared constants for the program-counter / branch controller
// Purpose: state encoding and branch condition codes used by pc_branch_ctrl
//          and br_cond_eval. No ports.
package pc_pkg;

    // Controller state encoding
    localparam logic [1:0] ST_RUN   = 2'd0;
    localparam logic [1:0] ST_EVAL  = 2'd1;
    localparam logic [1:0] ST_FLUSH = 2'd2;
    localparam logic [1:0] ST_HALT  = 2'd3;

    // Branch condition codes carried on Br_Cond
    localparam logic [1:0] COND_JMP = 2'b00;
    localparam logic [1:0] COND_JZ  = 2'b01;
    localparam logic [1:0] COND_JNZ = 2'b10;
    localparam logic [1:0] COND_RSV = 2'b11;

endpackage : pc_pkg

// File: rtl/br_cond_eval.sv
// rtl/br_cond_eval.sv - combinational branch condition evaluator
// Purpose: decide whether a branch with condition code cond is taken given
//          the equality flag z; flag the reserved code as an error.
// Ports:
//   cond  in  2  branch condition code (JMP/JZ/JNZ/RSV)
//   z     in  1  equality flag (1 = operands equal)
//   taken out 1  branch is taken
//   err   out 1  reserved condition code seen (never taken)
module br_cond_eval
    import pc_pkg::*;
(
    input  logic [1:0] cond,
    input  logic       z,
    output logic       taken,
    output logic       err
);

    always_comb begin
        taken = 1'b0;
        err   = 1'b0;
        unique case (cond)
            COND_JMP: taken = 1'b1;
            COND_JZ:  taken = z;
            COND_JNZ: taken = ~z;
            COND_RSV: err   = 1'b1;
            default:  err   = 1'b1;
        endcase
    end

endmodule : br_cond_eval

// File: rtl/pc_branch_ctrl.sv
// rtl/pc_branch_ctrl.sv - program counter and conditional branch controller
// Purpose: advances Pc on fetch handshakes, evaluates JMP/JZ/JNZ one cycle
//          after the decoder request, redirects Pc and inserts one fetch
//          bubble on a taken branch; supports halt/resume and direct load.
// Ports:
//   Clk, Rst_n          clock (rising edge), async active-low reset
//   z                   comparator equality flag, sampled only in EVAL
//   Pc_Ready            fetch side accepts current Pc
//   Br_Req/Br_Cond/Br_Target  single-cycle branch request from decoder
//   Load/Load_Val       synchronous Pc load, highest priority
//   Halt_Req/Resume     enter / leave HALT
//   Pc, Pc_Valid        current fetch address and its qualifier
//   Z_Flag              z as captured at branch evaluation
//   Taken, Cond_Err     one-cycle pulses after the evaluation edge
//   Busy                controller is not in RUN
module pc_branch_ctrl
    import pc_pkg::*;
#(
    parameter int              WIDTH    = 8,
    parameter logic [WIDTH-1:0] RESET_PC = '0
) (
    input  logic             Clk,
    input  logic             Rst_n,
    input  logic             z,
    input  logic             Pc_Ready,
    input  logic             Br_Req,
    input  logic [1:0]       Br_Cond,
    input  logic [WIDTH-1:0] Br_Target,
    input  logic             Load,
    input  logic [WIDTH-1:0] Load_Val,
    input  logic             Halt_Req,
    input  logic             Resume,
    output logic [WIDTH-1:0] Pc,
    output logic             Pc_Valid,
    output logic             Z_Flag,
    output logic             Taken,
    output logic             Cond_Err,
    output logic             Busy
);

    logic [1:0]       state_q,    state_d;
    logic [WIDTH-1:0] pc_q,       pc_d;
    logic [1:0]       cond_q,     cond_d;
    logic [WIDTH-1:0] target_q,   target_d;
    logic             z_flag_q,   z_flag_d;
    logic             taken_q,    taken_d;
    logic             cond_err_q, cond_err_d;

    logic             eval_taken;
    logic             eval_err;
    logic [WIDTH-1:0] pc_inc;

    // Evaluation uses the latched condition so the decoder may move on
    // while the comparator settles.
    br_cond_eval u_br_cond_eval (
        .cond  (cond_q),
        .z     (z),
        .taken (eval_taken),
        .err   (eval_err)
    );

    // Natural wrap modulo 2^WIDTH
    assign pc_inc = pc_q + WIDTH'(1);

    always_comb begin
        state_d    = state_q;
        pc_d       = pc_q;
        cond_d     = cond_q;
        target_d   = target_q;
        z_flag_d   = z_flag_q;
        taken_d    = 1'b0;
        cond_err_d = 1'b0;

        if (Load) begin
            // Load overrides everything and drops any pending branch;
            // the pulses stay low and Z_Flag keeps its last value.
            pc_d     = Load_Val;
            state_d  = ST_RUN;
            cond_d   = '0;
            target_d = '0;
        end else begin
            unique case (state_q)
                ST_RUN: begin
                    if (Halt_Req) begin
                        state_d = ST_HALT;
                    end else if (Br_Req) begin
                        // Branch wins over a concurrent fetch handshake:
                        // Pc is held until the branch resolves.
                        cond_d   = Br_Cond;
                        target_d = Br_Target;
                        state_d  = ST_EVAL;
                    end else if (Pc_Ready) begin
                        pc_d = pc_inc;
                    end
                end
                ST_EVAL: begin
                    z_flag_d   = z;
                    cond_err_d = eval_err;
                    if (eval_taken) begin
                        pc_d    = target_q;
                        taken_d = 1'b1;
                        state_d = ST_FLUSH;
                    end else begin
                        pc_d    = pc_inc;
                        state_d = ST_RUN;
                    end
                end
                ST_FLUSH: begin
                    // Single bubble; a Halt_Req here is picked up in RUN.
                    state_d = ST_RUN;
                end
                ST_HALT: begin
                    if (Resume) begin
                        state_d = ST_RUN;
                    end
                end
                default: begin
                    state_d = ST_RUN;
                end
            endcase
        end
    end

    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            state_q    <= ST_RUN;
            pc_q       <= RESET_PC;
            cond_q     <= '0;
            target_q   <= '0;
            z_flag_q   <= 1'b0;
            taken_q    <= 1'b0;
            cond_err_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            pc_q       <= pc_d;
            cond_q     <= cond_d;
            target_q   <= target_d;
            z_flag_q   <= z_flag_d;
            taken_q    <= taken_d;
            cond_err_q <= cond_err_d;
        end
    end

    assign Pc       = pc_q;
    assign Pc_Valid = (state_q == ST_RUN);
    assign Busy     = (state_q != ST_RUN);
    assign Z_Flag   = z_flag_q;
    assign Taken    = taken_q;
    assign Cond_Err = cond_err_q;

endmodule : pc_branch_ctrl

// File: tb/tb_pc_branch_ctrl.sv
// tb/tb_pc_branch_ctrl.sv - self-checking bench for pc_branch_ctrl
module tb_pc_branch_ctrl;

    logic       Clk = 1'b0;
    logic       Rst_n = 1'b0;
    logic       z = 1'b0;
    logic       Pc_Ready = 1'b0;
    logic       Br_Req = 1'b0;
    logic [1:0] Br_Cond = 2'b00;
    logic [7:0] Br_Target = 8'h00;
    logic       Load = 1'b0;
    logic [7:0] Load_Val = 8'h00;
    logic       Halt_Req = 1'b0;
    logic       Resume = 1'b0;
    logic [7:0] Pc;
    logic       Pc_Valid;
    logic       Z_Flag;
    logic       Taken;
    logic       Cond_Err;
    logic       Busy;

    pc_branch_ctrl #(.WIDTH(8), .RESET_PC(8'h00)) dut (
        .Clk       (Clk),
        .Rst_n     (Rst_n),
        .z         (z),
        .Pc_Ready  (Pc_Ready),
        .Br_Req    (Br_Req),
        .Br_Cond   (Br_Cond),
        .Br_Target (Br_Target),
        .Load      (Load),
        .Load_Val  (Load_Val),
        .Halt_Req  (Halt_Req),
        .Resume    (Resume),
        .Pc        (Pc),
        .Pc_Valid  (Pc_Valid),
        .Z_Flag    (Z_Flag),
        .Taken     (Taken),
        .Cond_Err  (Cond_Err),
        .Busy      (Busy)
    );

    always #5 Clk = ~Clk;

    int n_vec = 0;
    int n_err = 0;

    // Reference model: the controller described as activity flags
    int m_pc;
    bit m_halted, m_branch_pending, m_bubble;
    int m_cond, m_tgt;
    bit m_z, m_taken, m_err;

    task automatic check_val(input string tag, input int got, input int exp);
        n_vec++;
        if (got != exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic void model_reset();
        m_pc = 0; m_halted = 0; m_branch_pending = 0; m_bubble = 0;
        m_cond = 0; m_tgt = 0; m_z = 0; m_taken = 0; m_err = 0;
    endfunction

    function automatic void model_edge();
        bit take;
        if (!Rst_n) begin
            model_reset();
            return;
        end
        m_taken = 0;
        m_err   = 0;
        if (Load) begin
            m_pc = int'(Load_Val);
            m_halted = 0; m_branch_pending = 0; m_bubble = 0;
        end else if (m_branch_pending) begin
            m_z  = z;
            take = (m_cond == 0) || (m_cond == 1 && z) || (m_cond == 2 && !z);
            m_err = (m_cond == 3);
            if (take) begin
                m_pc = m_tgt; m_taken = 1; m_bubble = 1;
            end else begin
                m_pc = (m_pc + 1) % 256;
            end
            m_branch_pending = 0;
        end else if (m_bubble) begin
            m_bubble = 0;
        end else if (m_halted) begin
            if (Resume) m_halted = 0;
        end else if (Halt_Req) begin
            m_halted = 1;
        end else if (Br_Req) begin
            m_branch_pending = 1;
            m_cond = int'(Br_Cond);
            m_tgt  = int'(Br_Target);
        end else if (Pc_Ready) begin
            m_pc = (m_pc + 1) % 256;
        end
    endfunction

    task automatic check_all();
        bit fetching;
        fetching = !(m_halted || m_branch_pending || m_bubble);
        check_val("pc",       int'(Pc),       m_pc);
        check_val("pc_valid", int'(Pc_Valid), int'(fetching));
        check_val("busy",     int'(Busy),     int'(!fetching));
        check_val("z_flag",   int'(Z_Flag),   int'(m_z));
        check_val("taken",    int'(Taken),    int'(m_taken));
        check_val("cond_err", int'(Cond_Err), int'(m_err));
    endtask

    task automatic step();
        @(posedge Clk);
        model_edge();
        @(negedge Clk);
        check_all();
    endtask

    task automatic idle_inputs();
        z = 0; Pc_Ready = 0; Br_Req = 0; Br_Cond = 0; Br_Target = 0;
        Load = 0; Load_Val = 0; Halt_Req = 0; Resume = 0;
    endtask

    task automatic load_pc(input logic [7:0] v);
        idle_inputs();
        Load = 1; Load_Val = v;
        step();
        Load = 0;
    endtask

    task automatic branch(input logic [1:0] c, input logic [7:0] t, input bit rdy);
        idle_inputs();
        Br_Req = 1; Br_Cond = c; Br_Target = t; Pc_Ready = rdy;
        step();
        Br_Req = 0; Pc_Ready = 0;
    endtask

    initial begin
        model_reset();
        idle_inputs();
        Rst_n = 0;
        step();
        step();
        check_val("rst_pc", int'(Pc), 0);
        check_val("rst_valid", int'(Pc_Valid), 1);

        // Reset release and increment
        Rst_n = 1;
        Pc_Ready = 1;
        for (int i = 1; i <= 5; i++) begin
            step();
            check_val("inc_pc", int'(Pc), i);
        end

        // Taken JZ to 0x40
        load_pc(8'h10);
        branch(2'b01, 8'h40, 1'b0);
        check_val("jz_hold", int'(Pc), 'h10);
        z = 1;
        step();
        check_val("jz_pc", int'(Pc), 'h40);
        check_val("jz_taken", int'(Taken), 1);
        check_val("jz_zflag", int'(Z_Flag), 1);
        check_val("jz_flush", int'(Pc_Valid), 0);
        z = 0;
        step();
        check_val("jz_valid", int'(Pc_Valid), 1);
        check_val("jz_pulse", int'(Taken), 0);

        // Not-taken JNZ with concurrent Pc_Ready
        load_pc(8'h10);
        branch(2'b10, 8'h77, 1'b1);
        check_val("jnz_noinc", int'(Pc), 'h10);
        z = 1;
        step();
        check_val("jnz_pc", int'(Pc), 'h11);
        check_val("jnz_taken", int'(Taken), 0);
        check_val("jnz_valid", int'(Pc_Valid), 1);

        // Wrap, then reserved condition
        load_pc(8'hFF);
        Pc_Ready = 1;
        step();
        check_val("wrap_pc", int'(Pc), 0);
        branch(2'b11, 8'h55, 1'b0);
        step();
        check_val("rsv_err", int'(Cond_Err), 1);
        check_val("rsv_pc", int'(Pc), 1);
        check_val("rsv_taken", int'(Taken), 0);
        step();
        check_val("rsv_pulse", int'(Cond_Err), 0);

        // Load during EVAL of a JMP
        branch(2'b00, 8'h20, 1'b0);
        Load = 1; Load_Val = 8'h80;
        step();
        Load = 0;
        check_val("ld_pc", int'(Pc), 'h80);
        check_val("ld_valid", int'(Pc_Valid), 1);
        check_val("ld_taken", int'(Taken), 0);
        step();
        check_val("ld_taken2", int'(Taken), 0);

        // Halt, hold for 3 cycles, resume
        Halt_Req = 1;
        step();
        Halt_Req = 0; Pc_Ready = 1;
        for (int i = 0; i < 3; i++) begin
            step();
            check_val("halt_pc", int'(Pc), 'h80);
            check_val("halt_valid", int'(Pc_Valid), 0);
        end
        Resume = 1;
        step();
        Resume = 0;
        check_val("resume_valid", int'(Pc_Valid), 1);

        // Asynchronous reset while in FLUSH
        branch(2'b00, 8'h33, 1'b0);
        step();
        check_val("pre_rst_flush", int'(Pc_Valid), 0);
        #2 Rst_n = 0;
        #1;
        check_val("arst_pc", int'(Pc), 0);
        check_val("arst_valid", int'(Pc_Valid), 1);
        check_val("arst_taken", int'(Taken), 0);
        model_reset();
        step();
        Rst_n = 1;

        // Randomized traffic
        for (int n = 0; n < 600; n++) begin
            Pc_Ready  = ($urandom_range(0, 3) != 0);
            Br_Req    = ($urandom_range(0, 3) == 0);
            Br_Cond   = 2'($urandom_range(0, 3));
            Br_Target = 8'($urandom_range(0, 255));
            z         = 1'($urandom_range(0, 1));
            Load      = ($urandom_range(0, 19) == 0);
            Load_Val  = 8'($urandom_range(0, 255));
            Halt_Req  = ($urandom_range(0, 9) == 0);
            Resume    = ($urandom_range(0, 2) == 0);
            Rst_n     = ($urandom_range(0, 96) != 0);
            step();
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule : tb_pc_branch_ctrl
